// File: rtl/mul_seq_if.sv
// mul_seq_if: multiply-instruction handshake between decoder/regfile (master) and mul_seq (slave)
//   start, sgn, a, b           : instruction request and operands (master -> slave)
//   hold_pc, busy, done, w     : pipeline stall, occupancy, completion pulse, regfile write enable
//   product                    : 2N-bit result, valid while done=1 and held until the next accept
interface mul_seq_if #(parameter int N = 8);
  logic           start;
  logic           sgn;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           hold_pc;
  logic           busy;
  logic           done;
  logic           w;
  logic [2*N-1:0] product;
  modport master (output start, sgn, a, b, input hold_pc, busy, done, w, product);
  modport slave (input start, sgn, a, b, output hold_pc, busy, done, w, product);
endinterface

// File: rtl/mul_seq.sv
// mul_seq: sequential shift-add multiplier, N steps per instruction, signed or unsigned operands
//   clk, reset : clock and synchronous active-high reset
//   bus        : mul_seq_if slave (start/sgn/a/b in; hold_pc/busy/done/w/product out)
module mul_seq #(
  parameter int N = 8
) (
  input  logic     clk,
  input  logic     reset,
  mul_seq_if.slave bus
);
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   acc_q, acc_d, mpr_q, mpr_d, mcd_q, mcd_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d, busy_q, done_q;
  logic [N:0]     sum;
  logic [2*N-1:0] shifted;
  logic           accept, last;
  // {acc, mpr} is the running product; each step adds the multiplicand into the upper half
  // when the multiplier LSB is set, then shifts the whole pair right by one.
  assign sum     = {1'b0, acc_q} + (mpr_q[0] ? {1'b0, mcd_q} : '0);
  assign shifted = {sum, mpr_q[N-1:1]};
  assign accept  = (state_q == IDLE) && bus.start;
  assign last    = cnt_q == CW'(N - 1);
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mpr_d   = mpr_q;
    mcd_d   = mcd_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = RUN;
        acc_d   = '0;
        cnt_d   = '0;
        mcd_d   = (bus.sgn && bus.a[N-1]) ? -bus.a : bus.a;
        mpr_d   = (bus.sgn && bus.b[N-1]) ? -bus.b : bus.b;
        neg_d   = bus.sgn && (bus.a[N-1] ^ bus.b[N-1]);
      end
      RUN: begin
        acc_d = shifted[2*N-1:N];
        mpr_d = shifted[N-1:0];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          prod_d  = neg_q ? -shifted : shifted;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mpr_q   <= '0;
      mcd_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mpr_q   <= mpr_d;
      mcd_q   <= mcd_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
    end
  end
  assign bus.hold_pc = accept || (state_q == RUN);
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.w       = done_q;
  assign bus.product = prod_q;
endmodule
